// File: rtl/row_seq_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier: one shift-add row per clock, LSB first,
// with valid/ready handshakes on operand and product sides, one operation in flight.
module row_seq_multiplier #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROW = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0]   row;
  logic [WIDTH-1:0]   b_sh, pp;
  logic [WIDTH:0]     row_sum;
  logic               last_row;

  // Row datapath: add partial product to upper half keeping the carry, then shift right.
  assign b_sh     = b_reg >> row;
  assign pp       = b_sh[0] ? a_reg : '0;
  assign row_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, pp};
  assign acc_nxt  = {row_sum, acc[WIDTH-1:1]};
  assign last_row = (row == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = ROW;
      ROW:     if (last_row)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == ROW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      row     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= b;
          acc   <= '0;
          row   <= '0;
        end
        ROW: begin
          acc <= acc_nxt;
          row <= row + 1'b1;
          // product only moves on the way out of ROW and then holds through DONE/IDLE
          if (last_row) product <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_row_seq_multiplier.sv
// Directed and random checks of row_seq_multiplier against a cycle-level transaction model.
module tb_row_seq_multiplier;
  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*W-1:0] product;
  logic          busy;

  int n_chk = 0;
  int n_fail = 0;
  int dut_hs = 0;
  logic rand_on = 1'b0;

  row_seq_multiplier #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op occupies the block for W+1 edges counting the
  // accept edge, then presents a*b until the consumer takes it.
  logic          m_pend;
  int            m_cnt;
  logic [2*W-1:0] m_exp, m_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0; m_cnt <= 0; m_exp <= '0; m_last <= '0;
    end else if (!m_pend) begin
      if (in_valid) begin
        m_pend <= 1'b1;
        m_cnt  <= 1;
        m_exp  <= (2*W)'(a) * (2*W)'(b);
      end
    end else if (m_cnt < W + 1) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == W) m_last <= m_exp;
    end else if (out_ready) begin
      m_pend <= 1'b0;
    end
  end

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) dut_hs <= dut_hs + 1;

  always @(negedge clk) begin
    if (rst_n && m_cnt >= 0) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_pend && (m_cnt == W + 1)});
      chk("m_in_ready",  {31'd0, in_ready},  {31'd0, !m_pend});
      chk("m_busy",      {31'd0, busy},      {31'd0, m_pend && (m_cnt <= W)});
      chk("m_product",   {16'd0, product},   {16'd0, m_last});
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 100);
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  // Single op with out_ready held high; returns product and negedges from accept to out_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        output logic [2*W-1:0] p, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb;
    wait_ready();
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk); lat++; in_valid = 1'b0;
    end while (!out_valid && lat < 100);
    if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
    p = product;
    @(negedge clk);
    chk("single_pulse", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [2*W-1:0] p;
    int lat, hs0;

    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_product",   {16'd0, product},   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    run_op(8'd13, 8'd11, p, lat);
    chk("p_13x11", {16'd0, p}, 32'd143);
    chk("lat_13x11", lat, 9);

    // reset pulse while row 3 is being processed
    @(negedge clk);
    in_valid = 1'b1; a = 8'd200; b = 8'd100;
    wait_ready();
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    chk("midrow_rst_product",   {16'd0, product},   32'd0);
    chk("midrow_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_product",   {16'd0, product},   32'd0);
    chk("post_rst_in_ready",  {31'd0, in_ready},  32'd1);

    run_op(8'hFF, 8'hFF, p, lat);
    chk("p_ffxff", {16'd0, p}, 32'hFE01);
    run_op(8'h00, 8'hA5, p, lat);
    chk("p_0xa5", {16'd0, p}, 32'd0);
    chk("lat_0xa5", lat, 9);
    run_op(8'hA5, 8'h00, p, lat);
    chk("p_a5x0", {16'd0, p}, 32'd0);
    chk("lat_a5x0", lat, 9);
    run_op(8'hA5, 8'h3C, p, lat);
    chk("p_a5x3c", {16'd0, p}, 32'h26AC);

    // backpressure with new operands held on the input side
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd3; b = 8'd5;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    a = 8'd7; b = 8'd9;
    wait_out(lat);
    repeat (20) begin
      @(negedge clk);
      chk("bp_product",   {16'd0, product},   32'd15);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_busy", {31'd0, busy}, 32'd1);
    wait_out(lat);
    chk("bp_next_product", {16'd0, product}, 32'd63);

    // random back-to-back traffic with gaps on both sides
    @(negedge clk);
    hs0 = dut_hs;
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
          if (i % 97 == 0) begin a = '1; b = '1; end
          wait_ready();
          @(posedge clk);
          @(negedge clk);
          in_valid = 1'b0;
        end
        begin
          int t = 0;
          while (m_pend && t < 300) begin @(negedge clk); t++; end
          if (m_pend) chk("drain_timeout", 32'd0, 32'd1);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0) || !rand_on;
        end
      end
    join
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rand_op_count", dut_hs - hs0, 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
